// File: rtl/crack_range_if.sv
// crack_range_if: control, arc4-snoop and found-plaintext signals of one key-range cracker.
interface crack_range_if #(
   parameter int KEY_W = 24
);
   logic             en;
   logic             rdy;
   logic             stop;
   logic [KEY_W-1:0] start_key;
   logic [KEY_W-1:0] end_key;
   logic [7:0]       msg_len;
   logic [KEY_W-1:0] key;
   logic             key_valid;
   logic             key_fail;
   logic [KEY_W-1:0] keys_tried;
   logic             a4_en;
   logic             a4_rdy;
   logic [KEY_W-1:0] a4_key;
   logic [7:0]       a4_pt_addr;
   logic [7:0]       a4_pt_wrdata;
   logic             a4_pt_wren;
   logic [7:0]       fpt_addr;
   logic [7:0]       fpt_wrdata;
   logic             fpt_wren;
   modport slave (
      input  en, stop, start_key, end_key, msg_len, a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren,
      output rdy, key, key_valid, key_fail, keys_tried, a4_en, a4_key, fpt_addr, fpt_wrdata, fpt_wren
   );
   modport master (
      output en, stop, start_key, end_key, msg_len, a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren,
      input  rdy, key, key_valid, key_fail, keys_tried, a4_en, a4_key, fpt_addr, fpt_wrdata, fpt_wren
   );
endinterface

// File: rtl/crack_range.sv
// crack_range: sweeps keys start..end by KEY_STRIDE through an arc4 core, snooping each
// plaintext byte, and copies the plaintext of the first printable key to the fpt port.
module crack_range #(
   parameter int         KEY_W      = 24,
   parameter int         KEY_STRIDE = 1,
   parameter logic [7:0] CHAR_MIN   = 8'h20,
   parameter logic [7:0] CHAR_MAX   = 8'h7E,
   parameter int         MAX_LEN    = 255
) (
   input logic          clk,
   input logic          rst_n,
   crack_range_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, RUN, DECIDE, COPY, FOUND, FAILED} state_t;
   localparam logic [KEY_W:0] STRIDE  = (KEY_W+1)'(KEY_STRIDE);
   localparam logic [8:0]     LEN_CAP = 9'(MAX_LEN);
   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d, end_q, end_d, keys_tried_q, keys_tried_d;
   logic [7:0]       len_q, len_d, i_q, i_d;
   logic             key_valid_q, key_valid_d, key_fail_q, key_fail_d;
   logic             bad_q, bad_d, stop_q, stop_d;
   logic [7:0]       mem_q [MAX_LEN+1];
   logic             mem_we, stop_any, byte_bad, in_msg, wrap;
   logic [KEY_W:0]   next_key;
   assign stop_any = bus.stop | stop_q;
   assign mem_we   = state_q == RUN && bus.a4_pt_wren && {1'b0, bus.a4_pt_addr} <= LEN_CAP;
   assign in_msg   = bus.a4_pt_addr != 8'd0 && bus.a4_pt_addr <= len_q;
   assign byte_bad = bus.a4_pt_wrdata < CHAR_MIN || bus.a4_pt_wrdata > CHAR_MAX;
   // the carry bit catches a stride that would wrap past the top of the key space
   assign next_key = {1'b0, key_q} + STRIDE;
   assign wrap     = next_key[KEY_W] || next_key[KEY_W-1:0] > end_q;
   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      end_d        = end_q;
      len_d        = len_q;
      i_d          = i_q;
      keys_tried_d = keys_tried_q;
      key_valid_d  = key_valid_q;
      key_fail_d   = key_fail_q;
      bad_d        = bad_q;
      stop_d       = stop_q;
      case (state_q)
         IDLE, FOUND, FAILED: if (bus.en) begin
            state_d      = LAUNCH;
            key_d        = bus.start_key;
            end_d        = bus.end_key;
            len_d        = {1'b0, bus.msg_len} > LEN_CAP ? LEN_CAP[7:0] : bus.msg_len;
            keys_tried_d = '0;
            key_valid_d  = 1'b0;
            key_fail_d   = 1'b0;
            stop_d       = 1'b0;
         end
         LAUNCH: if (stop_any) begin
            state_d    = FAILED;
            key_fail_d = 1'b1;
         end else if (bus.a4_rdy) begin
            state_d = SETTLE;
            bad_d   = 1'b0;
         end
         SETTLE: begin
            stop_d  = stop_any;
            state_d = RUN;
         end
         RUN: begin
            stop_d  = stop_any;
            bad_d   = bad_q | (bus.a4_pt_wren & in_msg & byte_bad);
            state_d = bus.a4_rdy ? DECIDE : RUN;
         end
         DECIDE: begin
            keys_tried_d = keys_tried_q + 1'b1;
            i_d          = 8'd0;
            if (!stop_any && !bad_q) state_d = COPY;
            else if (stop_any || wrap) begin
               state_d    = FAILED;
               key_fail_d = 1'b1;
            end else begin
               key_d   = next_key[KEY_W-1:0];
               state_d = LAUNCH;
            end
         end
         COPY: if (i_q == len_q) begin
            state_d     = FOUND;
            key_valid_d = 1'b1;
         end else i_d = i_q + 8'd1;
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         key_q        <= '0;
         end_q        <= '0;
         len_q        <= '0;
         i_q          <= '0;
         keys_tried_q <= '0;
         key_valid_q  <= 1'b0;
         key_fail_q   <= 1'b0;
         bad_q        <= 1'b0;
         stop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         end_q        <= end_d;
         len_q        <= len_d;
         i_q          <= i_d;
         keys_tried_q <= keys_tried_d;
         key_valid_q  <= key_valid_d;
         key_fail_q   <= key_fail_d;
         bad_q        <= bad_d;
         stop_q       <= stop_d;
      end
   end
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[bus.a4_pt_addr] <= bus.a4_pt_wrdata;
   end
   assign bus.rdy        = state_q inside {IDLE, FOUND, FAILED};
   assign bus.key        = key_q;
   assign bus.a4_key     = key_q;
   assign bus.a4_en      = state_q == SETTLE;
   assign bus.key_valid  = key_valid_q;
   assign bus.key_fail   = key_fail_q;
   assign bus.keys_tried = keys_tried_q;
   assign bus.fpt_wren   = state_q == COPY;
   assign bus.fpt_addr   = state_q == COPY ? i_q : 8'd0;
   assign bus.fpt_wrdata = state_q == COPY ? mem_q[i_q] : 8'd0;
endmodule

// File: tb/tb_crack_range.sv
// tb_crack_range: directed searches against a behavioural arc4 model; launches, fpt writes
// and final results are pushed to queues and checked by an independent monitor.
module tb_crack_range;
   typedef struct packed {logic v; logic f; logic [23:0] k; logic [23:0] t;} res_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [23:0] exp_launch [$];
   logic [15:0] exp_fpt [$];
   res_t        exp_res [$];
   logic [7:0]  g_msg [4];
   logic [7:0]  b_msg [4];
   logic [23:0] good_key;
   int          wr_last = 3;
   int          busy = 0;
   crack_range_if #(.KEY_W(24)) bus();
   crack_range #(.KEY_W(24), .KEY_STRIDE(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic set_g(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      g_msg[0] = a; g_msg[1] = b; g_msg[2] = c; g_msg[3] = d;
   endtask
   task automatic set_b(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      b_msg[0] = a; b_msg[1] = b; b_msg[2] = c; b_msg[3] = d;
   endtask
   task automatic fpt(input logic [7:0] a, input logic [7:0] d);
      exp_fpt.push_back({a, d});
   endtask
   task automatic res(input logic v, input logic [23:0] k, input logic [23:0] t);
      exp_res.push_back({v, ~v, k, t});
   endtask
   task automatic start_search(input logic [23:0] s, input logic [23:0] e, input logic [7:0] len);
      @(negedge clk);
      bus.en = 1'b1; bus.start_key = s; bus.end_key = e; bus.msg_len = len;
      @(negedge clk);
      bus.en = 1'b0;
   endtask
   task automatic wait_done(input string name);
      int n = 0;
      while (exp_res.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk({name, "_result_seen"}, 32'(exp_res.size()), 32'd0);
      chk({name, "_launches_left"}, 32'(exp_launch.size()), 32'd0);
      chk({name, "_fpt_left"}, 32'(exp_fpt.size()), 32'd0);
      exp_res.delete(); exp_launch.delete(); exp_fpt.delete();
   endtask
   // arc4 model: after a4_en, optional busy gap, writes addr 0..wr_last one per cycle, then rdy
   initial begin
      logic [23:0] k;
      bus.a4_rdy = 1'b1; bus.a4_pt_wren = 1'b0; bus.a4_pt_addr = '0; bus.a4_pt_wrdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.a4_en) begin
            k = bus.a4_key;
            bus.a4_rdy = 1'b0;
            repeat (busy) @(negedge clk);
            for (int a = 0; a <= wr_last; a++) begin
               @(negedge clk);
               bus.a4_pt_wren = 1'b1;
               bus.a4_pt_addr = 8'(a);
               bus.a4_pt_wrdata = k == good_key ? g_msg[a] : b_msg[a];
            end
            @(negedge clk);
            bus.a4_pt_wren = 1'b0;
            bus.a4_rdy = 1'b1;
         end
      end
   end
   // monitor
   initial begin
      logic prev_done = 1'b0;
      logic [23:0] lk;
      logic [15:0] fw;
      res_t r;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.a4_en) begin
               if (exp_launch.size() == 0) chk("launch_unexpected", 32'(bus.a4_key), 32'hFFFF_FFFF);
               else begin
                  lk = exp_launch.pop_front();
                  chk("launch_key", 32'(bus.a4_key), 32'(lk));
               end
            end
            if (bus.fpt_wren) begin
               chk("fpt_after_last_launch", 32'(exp_launch.size()), 32'd0);
               if (exp_fpt.size() == 0) chk("fpt_unexpected", 32'({bus.fpt_addr, bus.fpt_wrdata}), 32'hFFFF_FFFF);
               else begin
                  fw = exp_fpt.pop_front();
                  chk("fpt_addr", 32'(bus.fpt_addr), 32'(fw[15:8]));
                  chk("fpt_data", 32'(bus.fpt_wrdata), 32'(fw[7:0]));
               end
            end
            if ((bus.key_valid | bus.key_fail) && !prev_done) begin
               if (exp_res.size() == 0) chk("result_unexpected", 32'({bus.key_valid, bus.key_fail}), 32'd0);
               else begin
                  r = exp_res.pop_front();
                  chk("res_valid", 32'(bus.key_valid), 32'(r.v));
                  chk("res_fail", 32'(bus.key_fail), 32'(r.f));
                  chk("res_key", 32'(bus.key), 32'(r.k));
                  chk("res_tried", 32'(bus.keys_tried), 32'(r.t));
                  chk("res_rdy", 32'(bus.rdy), 32'd1);
                  chk("res_no_fpt", 32'(bus.fpt_wren), 32'd0);
               end
            end
            prev_done = bus.key_valid | bus.key_fail;
         end
      end
   end
   initial begin
      bus.en = 1'b0; bus.stop = 1'b0; bus.start_key = '0; bus.end_key = '0; bus.msg_len = '0;
      good_key = 24'h100;
      set_g(8'h00, 8'h00, 8'h00, 8'h00);
      set_b(8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdy", 32'(bus.rdy), 32'd1);
      chk("rst_key", 32'(bus.key), 32'd0);
      chk("rst_valid_fail", 32'({bus.key_valid, bus.key_fail}), 32'd0);
      chk("rst_tried", 32'(bus.keys_tried), 32'd0);
      chk("rst_a4_en", 32'(bus.a4_en), 32'd0);
      chk("rst_fpt", 32'({bus.fpt_wren, bus.fpt_addr, bus.fpt_wrdata}), 32'd0);
      // first key accepted
      set_g(8'd3, "a", "b", "c"); good_key = 24'h10; wr_last = 3;
      exp_launch.push_back(24'h10);
      fpt(0, 8'd3); fpt(1, 8'h61); fpt(2, 8'h62); fpt(3, 8'h63);
      res(1, 24'h10, 1);
      start_search(24'h10, 24'h10, 8'd3);
      wait_done("first_key");
      // stride 2 search, only key 7 passes
      set_g(8'd2, "h", "i", 8'h00); set_b(8'd2, "h", 8'h80, 8'h00); good_key = 24'h07; wr_last = 2;
      exp_launch.push_back(24'h01); exp_launch.push_back(24'h03);
      exp_launch.push_back(24'h05); exp_launch.push_back(24'h07);
      fpt(0, 8'd2); fpt(1, 8'h68); fpt(2, 8'h69);
      res(1, 24'h07, 4);
      start_search(24'h01, 24'h0F, 8'd2);
      wait_done("stride");
      // exhaustion
      set_b(8'h7F, 8'h7F, 8'h7F, 8'h7F); good_key = 24'h100;
      exp_launch.push_back(24'h00); exp_launch.push_back(24'h02); exp_launch.push_back(24'h04);
      res(0, 24'h04, 3);
      start_search(24'h00, 24'h05, 8'd2);
      wait_done("exhaust");
      // wrap guard
      exp_launch.push_back(24'hFFFFFE);
      res(0, 24'hFFFFFE, 1);
      start_search(24'hFFFFFE, 24'hFFFFFF, 8'd2);
      wait_done("wrap");
      // boundary bytes accepted, trailing 0x00 beyond len ignored
      set_g(8'd2, 8'h20, 8'h7E, 8'h00); good_key = 24'h40; wr_last = 3;
      exp_launch.push_back(24'h40);
      fpt(0, 8'd2); fpt(1, 8'h20); fpt(2, 8'h7E);
      res(1, 24'h40, 1);
      start_search(24'h40, 24'h40, 8'd2);
      wait_done("boundary_ok");
      // 0x1F at addr 1 rejected
      set_b(8'd2, 8'h1F, 8'h41, 8'h00); good_key = 24'h100; wr_last = 2;
      exp_launch.push_back(24'h41);
      res(0, 24'h41, 1);
      start_search(24'h41, 24'h41, 8'd2);
      wait_done("boundary_bad");
      // zero length: first key accepted, one copy byte
      set_b(8'h00, 8'h7F, 8'h7F, 8'h7F);
      exp_launch.push_back(24'h03);
      fpt(0, 8'h00);
      res(1, 24'h03, 1);
      start_search(24'h03, 24'h09, 8'd0);
      wait_done("zero_len");
      // stop while arc4 busy: fails even though the key is good
      set_g(8'd2, "o", "k", 8'h00); good_key = 24'h00; busy = 6;
      exp_launch.push_back(24'h00);
      res(0, 24'h00, 1);
      start_search(24'h00, 24'h10, 8'd2);
      begin
         int n = 0;
         while (!bus.a4_en && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("stop_launch_seen", 32'(bus.a4_en), 32'd1);
      end
      repeat (2) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      wait_done("stop");
      // restart after abort
      busy = 0;
      exp_launch.push_back(24'h00);
      fpt(0, 8'd2); fpt(1, 8'h6F); fpt(2, 8'h6B);
      res(1, 24'h00, 1);
      start_search(24'h00, 24'h10, 8'd2);
      chk("restart_tried", 32'(bus.keys_tried), 32'd0);
      chk("restart_fail_clr", 32'(bus.key_fail), 32'd0);
      chk("restart_busy", 32'(bus.rdy), 32'd0);
      wait_done("restart");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
